mem_arbiter: RTL and testbench

- Two-requester arbiter and sequencer for the single-port unified memory (combinational read, write on posedge clk).
- Shares the memory between the instruction-fetch port (read-only, word) and the load/store data port (byte/half/word, signed/unsigned, read/write).
- Registers each granted command, drives the memory for exactly one cycle, and returns a registered response.
- Filters out-of-range and misaligned accesses before they reach the memory.

---
 rtl/mem_pkg.sv | 29 ++
 rtl/mem_arbiter_if.sv | 47 ++++
 rtl/mem_access_check.sv | 32 +++
 rtl/mem_arbiter.sv | 145 ++++++++++++++
 tb/tb_mem_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared constants, state and owner encodings for the memory arbiter
package mem_pkg;

  localparam logic [1:0]  BYTE     = 2'b00;
  localparam logic [1:0]  HALFWORD = 2'b01;
  localparam logic [1:0]  WORD     = 2'b10;
  localparam logic [31:0] BAD_DATA = 32'hBADB_ADFF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_e;

  // Reserved size 2'b11 reports 4 bytes; it is rejected separately.
  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      BYTE:     size_bytes = 3'd1;
      HALFWORD: size_bytes = 3'd2;
      default:  size_bytes = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - fetch, data and memory-side signals of the arbiter
interface mem_arbiter_if;

  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ready;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        if_fault;

  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [1:0]  d_size;
  logic        d_unsigned;
  logic        d_ready;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        d_fault;

  logic [31:0] m_address;
  logic [31:0] m_data_in;
  logic        m_w_enable;
  logic [1:0]  m_access_size;
  logic        m_RdUn;
  logic [31:0] m_data_out;

  modport slave (
    input  if_req, if_addr,
    output if_ready, if_rvalid, if_rdata, if_fault,
    input  d_req, d_we, d_addr, d_wdata, d_size, d_unsigned,
    output d_ready, d_rvalid, d_rdata, d_fault,
    output m_address, m_data_in, m_w_enable, m_access_size, m_RdUn,
    input  m_data_out
  );

  modport master (
    output if_req, if_addr,
    input  if_ready, if_rvalid, if_rdata, if_fault,
    output d_req, d_we, d_addr, d_wdata, d_size, d_unsigned,
    input  d_ready, d_rvalid, d_rdata, d_fault,
    input  m_address, m_data_in, m_w_enable, m_access_size, m_RdUn,
    output m_data_out
  );

endinterface

// File: rtl/mem_access_check.sv
// rtl/mem_access_check.sv - combinational range, alignment and size checker
module mem_access_check
  import mem_pkg::*;
#(
  parameter logic [31:0] START_ADDR = 32'h0100_0000,
  parameter logic [31:0] MEM_SIZE   = 32'd1048576
) (
  input  logic [31:0] addr_i,
  input  logic [1:0]  size_i,
  output logic        fault_o
);

  logic [32:0] first_byte;
  logic [32:0] last_byte;
  logic [32:0] last_valid;
  logic        misaligned;
  logic        bad_size;
  logic        out_of_range;

  // 33-bit sums keep an access near 32'hFFFF_FFFF from wrapping back into range.
  assign first_byte   = {1'b0, addr_i};
  assign last_byte    = first_byte + {30'b0, size_bytes(size_i)} - 33'd1;
  assign last_valid   = {1'b0, START_ADDR} + {1'b0, MEM_SIZE} - 33'd1;

  assign misaligned   = ((size_i == HALFWORD) && addr_i[0]) ||
                        ((size_i == WORD) && (addr_i[1:0] != 2'b00));
  assign bad_size     = (size_i == 2'b11);
  assign out_of_range = (first_byte < {1'b0, START_ADDR}) || (last_byte > last_valid);

  assign fault_o      = misaligned || bad_size || out_of_range;

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fetch/data arbiter and one-access sequencer for the unified memory
module mem_arbiter
  import mem_pkg::*;
#(
  parameter logic [31:0] START_ADDR = 32'h0100_0000,
  parameter logic [31:0] MEM_SIZE   = 32'd1048576,
  parameter int unsigned MAX_STREAK = 4
) (
  input logic          clk,
  input logic          rst_n,
  mem_arbiter_if.slave bus
);

  localparam logic [3:0] STREAK_MAX = 4'(MAX_STREAK);

  state_e      state_q;
  logic [3:0]  streak_q;
  logic [3:0]  streak_d;

  owner_e      cmd_owner_q;
  logic [31:0] cmd_addr_q;
  logic [31:0] cmd_wdata_q;
  logic [1:0]  cmd_size_q;
  logic        cmd_we_q;
  logic        cmd_uns_q;
  logic        cmd_fault_q;

  logic        if_rvalid_q;
  logic        if_fault_q;
  logic [31:0] if_rdata_q;
  logic        d_rvalid_q;
  logic        d_fault_q;
  logic [31:0] d_rdata_q;

  logic        grant_if;
  logic        grant_d;
  logic [31:0] chk_addr;
  logic [1:0]  chk_size;
  logic        chk_fault;

  // Data normally wins; a fetch that has waited out a full streak takes the next slot.
  always_comb begin
    grant_d  = 1'b0;
    grant_if = 1'b0;
    if (state_q != ACCESS) begin
      grant_d  = bus.d_req && !(bus.if_req && (streak_q == STREAK_MAX));
      grant_if = bus.if_req && !grant_d;
    end
  end

  always_comb begin
    streak_d = streak_q;
    if (!bus.if_req || grant_if) begin
      streak_d = 4'd0;
    end else if (grant_d && (streak_q < STREAK_MAX)) begin
      streak_d = streak_q + 4'd1;
    end
  end

  assign chk_addr = grant_d ? bus.d_addr : bus.if_addr;
  assign chk_size = grant_d ? bus.d_size : WORD;

  mem_access_check #(
    .START_ADDR (START_ADDR),
    .MEM_SIZE   (MEM_SIZE)
  ) u_access_check (
    .addr_i  (chk_addr),
    .size_i  (chk_size),
    .fault_o (chk_fault)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      streak_q    <= 4'd0;
      cmd_owner_q <= OWN_IF;
      cmd_addr_q  <= 32'd0;
      cmd_wdata_q <= 32'd0;
      cmd_size_q  <= 2'd0;
      cmd_we_q    <= 1'b0;
      cmd_uns_q   <= 1'b0;
      cmd_fault_q <= 1'b0;
      if_rvalid_q <= 1'b0;
      if_fault_q  <= 1'b0;
      if_rdata_q  <= 32'd0;
      d_rvalid_q  <= 1'b0;
      d_fault_q   <= 1'b0;
      d_rdata_q   <= 32'd0;
    end else begin
      streak_q    <= streak_d;
      if_rvalid_q <= 1'b0;
      if_fault_q  <= 1'b0;
      d_rvalid_q  <= 1'b0;
      d_fault_q   <= 1'b0;
      case (state_q)
        IDLE, RESP: begin
          if (grant_if || grant_d) begin
            state_q     <= ACCESS;
            cmd_owner_q <= grant_d ? OWN_D : OWN_IF;
            cmd_addr_q  <= chk_addr;
            cmd_size_q  <= chk_size;
            cmd_we_q    <= grant_d && bus.d_we;
            cmd_wdata_q <= grant_d ? bus.d_wdata : 32'd0;
            cmd_uns_q   <= grant_d && bus.d_unsigned;
            cmd_fault_q <= chk_fault;
          end else begin
            state_q <= IDLE;
          end
        end
        ACCESS: begin
          state_q <= RESP;
          if (cmd_owner_q == OWN_IF) begin
            if_rvalid_q <= 1'b1;
            if_fault_q  <= cmd_fault_q;
            if_rdata_q  <= cmd_fault_q ? BAD_DATA : bus.m_data_out;
          end else begin
            d_rvalid_q <= 1'b1;
            d_fault_q  <= cmd_fault_q;
            d_rdata_q  <= cmd_fault_q ? BAD_DATA :
                          (cmd_we_q ? 32'd0 : bus.m_data_out);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.if_ready  = grant_if;
  assign bus.d_ready   = grant_d;
  assign bus.if_rvalid = if_rvalid_q;
  assign bus.if_fault  = if_fault_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_rvalid  = d_rvalid_q;
  assign bus.d_fault   = d_fault_q;
  assign bus.d_rdata   = d_rdata_q;

  // Command fields only change on a grant, so the bus holds its last values outside ACCESS;
  // the write strobe is decoded from live state so an async reset kills it at once.
  assign bus.m_address     = cmd_addr_q;
  assign bus.m_data_in     = cmd_wdata_q;
  assign bus.m_access_size = cmd_size_q;
  assign bus.m_RdUn        = cmd_uns_q;
  assign bus.m_w_enable    = (state_q == ACCESS) && cmd_we_q && !cmd_fault_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - randomized self-checking bench for mem_arbiter with a reference model
module tb_mem_arbiter;
  import mem_pkg::*;

  localparam logic [31:0] START      = 32'h0100_0000;
  localparam logic [31:0] MSIZE      = 32'd1048576;
  localparam int          MAX_STREAK = 4;
  localparam int          MEM_BYTES  = 1048576;

  logic clk;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  mem_arbiter_if bus ();

  mem_arbiter #(
    .START_ADDR (START),
    .MEM_SIZE   (MSIZE),
    .MAX_STREAK (MAX_STREAK)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory device: combinational read, little-endian, write on posedge.
  bit [7:0]    mem [MEM_BYTES] = '{default: 8'h00};
  logic [31:0] mem_off;
  logic [19:0] i0, i1, i2, i3;
  assign mem_off = bus.m_address - START;
  assign i0 = mem_off[19:0];
  assign i1 = i0 + 20'd1;
  assign i2 = i0 + 20'd2;
  assign i3 = i0 + 20'd3;

  always_comb begin
    bus.m_data_out = {mem[i3], mem[i2], mem[i1], mem[i0]};
    case (bus.m_access_size)
      2'b00: bus.m_data_out = bus.m_RdUn ? {24'd0, mem[i0]} : {{24{mem[i0][7]}}, mem[i0]};
      2'b01: bus.m_data_out = bus.m_RdUn ? {16'd0, mem[i1], mem[i0]}
                                         : {{16{mem[i1][7]}}, mem[i1], mem[i0]};
      default: ;
    endcase
  end

  always @(posedge clk) begin
    if (bus.m_w_enable) begin
      mem[i0] <= bus.m_data_in[7:0];
      if (bus.m_access_size != 2'b00) mem[i1] <= bus.m_data_in[15:8];
      if (bus.m_access_size[1]) begin
        mem[i2] <= bus.m_data_in[23:16];
        mem[i3] <= bus.m_data_in[31:24];
      end
    end
  end

  // Reference model: byte-addressed contents keyed by offset, plus the access rules.
  bit [7:0] ref_mem [int unsigned];

  function automatic logic [7:0] ref_byte(input int unsigned k);
    return ref_mem.exists(k) ? ref_mem[k] : 8'h00;
  endfunction

  function automatic bit model_fault(input logic [31:0] a, input logic [1:0] sz);
    longint nb;
    longint lo;
    if (sz == 2'b11) return 1'b1;
    nb = (sz == 2'b00) ? 1 : ((sz == 2'b01) ? 2 : 4);
    lo = longint'({32'd0, a});
    if ((lo % nb) != 0) return 1'b1;
    return (lo < longint'({32'd0, START})) ||
           (lo + nb - 1 > longint'({32'd0, START}) + longint'({32'd0, MSIZE}) - 1);
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] sz, input bit uns);
    int unsigned off;
    logic [7:0]  b0, b1, b2, b3;
    off = a - START;
    b0 = ref_byte(off);
    b1 = ref_byte(off + 1);
    b2 = ref_byte(off + 2);
    b3 = ref_byte(off + 3);
    if (sz == 2'b00) return uns ? {24'd0, b0} : {{24{b0[7]}}, b0};
    if (sz == 2'b01) return uns ? {16'd0, b1, b0} : {{16{b1[7]}}, b1, b0};
    return {b3, b2, b1, b0};
  endfunction

  task automatic ref_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd);
    int unsigned off;
    int          nb;
    off = a - START;
    nb  = (sz == 2'b00) ? 1 : ((sz == 2'b01) ? 2 : 4);
    for (int k = 0; k < nb; k++) ref_mem[off + k] = wd[8*k +: 8];
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.if_req     = 1'b0;
    bus.if_addr    = 32'd0;
    bus.d_req      = 1'b0;
    bus.d_we       = 1'b0;
    bus.d_addr     = 32'd0;
    bus.d_wdata    = 32'd0;
    bus.d_size     = 2'b00;
    bus.d_unsigned = 1'b0;
  endtask

  // One isolated transaction: grant in the first cycle, access next, response after.
  task automatic run_txn(input bit fetch, input logic [31:0] addr, input bit we_in,
                         input logic [1:0] sz_in, input bit uns_in, input logic [31:0] wdata,
                         output logic [31:0] got);
    bit          we;
    logic [1:0]  sz;
    bit          uns;
    bit          exp_fault;
    logic [31:0] exp_data;
    logic [31:0] other_rdata;
    int          n;
    string       nm;
    we  = fetch ? 1'b0 : we_in;
    sz  = fetch ? WORD : sz_in;
    uns = fetch ? 1'b0 : uns_in;
    nm  = $sformatf("%s_%s_%h", fetch ? "if" : "d", we ? "st" : "ld", addr);
    exp_fault = model_fault(addr, sz);
    exp_data  = exp_fault ? BAD_DATA : (we ? 32'd0 : model_load(addr, sz, uns));
    got = 32'd0;

    @(posedge clk); #1;
    if (fetch) begin
      bus.if_req  = 1'b1;
      bus.if_addr = addr;
    end else begin
      bus.d_req      = 1'b1;
      bus.d_we       = we;
      bus.d_addr     = addr;
      bus.d_wdata    = wdata;
      bus.d_size     = sz;
      bus.d_unsigned = uns;
    end
    @(negedge clk);
    n = 0;
    while (!(fetch ? bus.if_ready : bus.d_ready) && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({nm, "_grant_lat"}, 32'(n), 32'd0);
    check({nm, "_ready_pair"}, {30'd0, bus.if_ready, bus.d_ready},
          fetch ? 32'd2 : 32'd1);
    other_rdata = fetch ? bus.d_rdata : bus.if_rdata;
    @(posedge clk); #1;
    clear_inputs();
    if (n >= 20) return;

    @(negedge clk);
    check({nm, "_acc_ready"}, {30'd0, bus.if_ready, bus.d_ready}, 32'd0);
    check({nm, "_m_address"}, bus.m_address, addr);
    check({nm, "_m_size"}, {30'd0, bus.m_access_size}, {30'd0, sz});
    check({nm, "_m_w_enable"}, {31'd0, bus.m_w_enable}, {31'd0, we && !exp_fault});
    if (we && !exp_fault) check({nm, "_m_data_in"}, bus.m_data_in, wdata);
    if (!fetch && !we) check({nm, "_m_rdun"}, {31'd0, bus.m_RdUn}, {31'd0, uns});

    @(negedge clk);
    check({nm, "_rvalid_pair"}, {30'd0, bus.if_rvalid, bus.d_rvalid},
          fetch ? 32'd2 : 32'd1);
    got = fetch ? bus.if_rdata : bus.d_rdata;
    check({nm, "_rdata"}, got, exp_data);
    check({nm, "_fault"}, {31'd0, fetch ? bus.if_fault : bus.d_fault}, {31'd0, exp_fault});
    check({nm, "_other_hold"}, fetch ? bus.d_rdata : bus.if_rdata, other_rdata);
    if (we && !exp_fault) ref_store(addr, sz, wdata);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] got;
    logic [31:0] ra;
    logic [1:0]  rs;
    int          grants;
    int          last_cyc;
    int          streak;
    int          n;

    clear_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_outputs", {26'd0, bus.if_ready, bus.d_ready, bus.if_rvalid, bus.d_rvalid,
                          bus.if_fault, bus.d_fault}, 32'd0);
    check("rst_rdata_or", bus.if_rdata | bus.d_rdata, 32'd0);
    check("rst_m_bus", bus.m_address | bus.m_data_in | {29'd0, bus.m_w_enable,
                       bus.m_access_size}, 32'd0);
    check("rst_state", 32'(dut.state_q), 32'(IDLE));
    check("rst_streak", 32'(dut.streak_q), 32'd0);
    check("rst_owner", 32'(dut.cmd_owner_q), 32'(OWN_IF));
    rst_n = 1'b1;

    run_txn(1'b0, START, 1'b1, WORD, 1'b0, 32'h0000_0513, got);
    run_txn(1'b1, START, 1'b0, WORD, 1'b0, 32'd0, got);
    check("fetch_insn_const", got, 32'h0000_0513);

    run_txn(1'b0, START + 32'h101, 1'b1, BYTE, 1'b0, 32'h0000_0080, got);
    check("sb_rdata_zero", got, 32'd0);
    run_txn(1'b0, START + 32'h101, 1'b0, BYTE, 1'b0, 32'd0, got);
    check("lb_signed_const", got, 32'hFFFF_FF80);
    run_txn(1'b0, START + 32'h101, 1'b0, BYTE, 1'b1, 32'd0, got);
    check("lb_unsigned_const", got, 32'h0000_0080);

    run_txn(1'b0, 32'h0100_0002, 1'b1, WORD, 1'b0, 32'hCAFE_F00D, got);
    check("flt_misalign_st", got, BAD_DATA);
    run_txn(1'b0, 32'h0110_0000, 1'b0, WORD, 1'b0, 32'd0, got);
    check("flt_range_ld", got, BAD_DATA);
    run_txn(1'b0, 32'h0100_FFFF, 1'b0, HALFWORD, 1'b0, 32'd0, got);
    check("flt_half_ld", got, BAD_DATA);
    run_txn(1'b0, START + 32'h10, 1'b1, 2'b11, 1'b0, 32'h1111_2222, got);
    check("flt_size11", got, BAD_DATA);

    run_txn(1'b0, 32'h010F_FFFC, 1'b1, WORD, 1'b0, 32'hA5A5_5A5A, got);
    run_txn(1'b0, 32'h010F_FFFC, 1'b0, WORD, 1'b0, 32'd0, got);
    check("bnd_last_word", got, 32'hA5A5_5A5A);
    run_txn(1'b0, 32'h010F_FFFD, 1'b0, WORD, 1'b0, 32'd0, got);
    check("bnd_past_end", got, BAD_DATA);
    run_txn(1'b1, 32'hFFFF_FFFC, 1'b0, WORD, 1'b0, 32'd0, got);
    check("bnd_fetch_top", got, BAD_DATA);

    // Contention: both requesters held high; expected order from the streak rule.
    @(posedge clk); #1;
    bus.if_req  = 1'b1;
    bus.if_addr = START;
    bus.d_req   = 1'b1;
    bus.d_addr  = START + 32'd4;
    bus.d_size  = WORD;
    grants   = 0;
    last_cyc = 0;
    streak   = 0;
    for (int cyc = 0; cyc < 60 && grants < 10; cyc++) begin
      @(negedge clk);
      if (bus.if_ready || bus.d_ready) begin
        check($sformatf("cont_one_ready_%0d", grants),
              32'(bus.if_ready) + 32'(bus.d_ready), 32'd1);
        check($sformatf("cont_owner_%0d", grants), {31'd0, bus.d_ready},
              {31'd0, streak != MAX_STREAK});
        if (grants > 0) check($sformatf("cont_gap_%0d", grants), 32'(cyc - last_cyc), 32'd2);
        streak   = (streak != MAX_STREAK) ? streak + 1 : 0;
        last_cyc = cyc;
        grants++;
      end
    end
    check("cont_grants", 32'(grants), 32'd10);
    @(posedge clk); #1;
    clear_inputs();
    repeat (3) @(negedge clk);

    for (int t = 0; t < 200; t++) begin
      case ($urandom_range(0, 3))
        0:       ra = START + 32'($urandom_range(0, 255));
        1:       ra = START + MSIZE - 32'd8 + 32'($urandom_range(0, 15));
        2:       ra = $urandom;
        default: ra = START - 32'($urandom_range(1, 8));
      endcase
      if ($urandom_range(0, 1) == 1) ra[1:0] = 2'b00;
      rs = 2'($urandom_range(0, 3));
      run_txn($urandom_range(0, 3) == 0, ra, $urandom_range(0, 1) == 1, rs,
              $urandom_range(0, 1) == 1, $urandom, got);
    end

    // Reset in the middle of a store's access cycle.
    run_txn(1'b0, START + 32'h40, 1'b1, WORD, 1'b0, 32'h1234_5678, got);
    @(posedge clk); #1;
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b1;
    bus.d_addr  = START + 32'h40;
    bus.d_wdata = 32'hDEAD_BEEF;
    bus.d_size  = WORD;
    n = 0;
    @(negedge clk);
    while (!bus.d_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("rst_mid_grant", 32'(n), 32'd0);
    @(posedge clk); #1;
    clear_inputs();
    check("rst_mid_wen_before", {31'd0, bus.m_w_enable}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_wen_async", {31'd0, bus.m_w_enable}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("rst_mid_no_rvalid_%0d", c), {30'd0, bus.if_rvalid, bus.d_rvalid}, 32'd0);
    end
    check("rst_mid_state", 32'(dut.state_q), 32'(IDLE));
    check("rst_mid_streak", 32'(dut.streak_q), 32'd0);
    check("rst_mid_mem_keep", {mem[20'h43], mem[20'h42], mem[20'h41], mem[20'h40]},
          32'h1234_5678);
    run_txn(1'b0, START + 32'h40, 1'b0, WORD, 1'b0, 32'd0, got);
    check("rst_mid_reload", got, 32'h1234_5678);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
